// File: rtl/fnd_scan_rx.sv
// rtl/fnd_scan_rx.sv - seven-segment scan bus receiver with frame capture and BCD decode
module fnd_scan_rx #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2**20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic [23:0] o_digits,
    output logic [6:0]  o_value,
    output logic        o_frame_valid,
    output logic        o_err,
    output logic        o_stale
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_SETTLE  = 2'd1;
    localparam logic [1:0]  ST_HOLD    = 2'd2;
    localparam logic [31:0] SETTLE_CNT = 32'(SETTLE);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

    logic [6:0]  seg_m, seg_s;
    logic        dp_m, dp_s;
    logic [5:0]  enb_m, enb_s, enb_q;

    logic [1:0]  state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] tmo_cnt;
    logic [5:0]  mask;
    logic [41:0] seg_buf, seg_buf_nx;
    logic [5:0]  dp_buf, dp_buf_nx;

    logic [5:0]  act;
    logic [2:0]  slot;
    logic        legal, blank, fresh, cap, err_nx, complete, tmo_hit;
    logic [23:0] dig_nx;
    logic [6:0]  value_nx;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 4'h0;
            7'b0110000: decode = 4'h1;
            7'b1101101: decode = 4'h2;
            7'b1111001: decode = 4'h3;
            7'b0110011: decode = 4'h4;
            7'b1011011: decode = 4'h5;
            7'b1011111: decode = 4'h6;
            7'b1110000: decode = 4'h7;
            7'b1111111: decode = 4'h8;
            7'b1110011: decode = 4'h9;
            7'b0000000: decode = 4'hA;
            default:    decode = 4'hF;
        endcase
    endfunction

    // Two-flop synchronizers; enables reset to blank so no slot looks active out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m <= '0;
            seg_s <= '0;
            dp_m  <= 1'b0;
            dp_s  <= 1'b0;
            enb_m <= '1;
            enb_s <= '1;
            enb_q <= '1;
        end else begin
            seg_m <= i_seg;
            seg_s <= seg_m;
            dp_m  <= i_seg_dp;
            dp_s  <= dp_m;
            enb_m <= i_seg_enb;
            enb_s <= enb_m;
            enb_q <= enb_s;
        end
    end

    always_comb begin
        act   = ~enb_s;
        legal = (act != 6'd0) && ((act & (act - 6'd1)) == 6'd0);
        blank = (act == 6'd0);
        slot  = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (act[k]) slot = 3'(k);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fresh    = 1'b0;
        cap      = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (enb_s == enb_q) cnt_nx = cnt + 32'd1;
                else                fresh  = 1'b1;
            end
            ST_HOLD:   fresh = (enb_s != enb_q);
            default:   fresh = 1'b1;
        endcase
        if (fresh) begin
            if (legal) begin
                state_nx = ST_SETTLE;
                cnt_nx   = 32'd1;
            end else begin
                state_nx = ST_IDLE;
                cnt_nx   = 32'd0;
                err_nx   = !blank;
            end
        end
        if (state_nx == ST_SETTLE && cnt_nx == SETTLE_CNT) begin
            cap      = 1'b1;
            state_nx = ST_HOLD;
        end
    end

    assign complete = (mask == 6'h3F);
    assign tmo_hit  = !cap && (tmo_cnt == TMO_LAST);

    // Forward a same-cycle capture into the published frame
    always_comb begin
        seg_buf_nx = seg_buf;
        dp_buf_nx  = dp_buf;
        dig_nx     = '0;
        if (cap) begin
            seg_buf_nx[7*slot +: 7] = seg_s;
            dp_buf_nx[slot]         = dp_s;
        end
        for (int k = 0; k < 6; k++) begin
            dig_nx[4*k +: 4] = decode(seg_buf_nx[7*k +: 7]);
        end
        if (dig_nx[7:4] > 4'd9 || dig_nx[3:0] > 4'd9) value_nx = 7'h7F;
        else value_nx = {3'd0, dig_nx[7:4]} * 7'd10 + {3'd0, dig_nx[3:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            tmo_cnt         <= '0;
            mask            <= '0;
            seg_buf         <= '0;
            dp_buf          <= '0;
            o_six_digit_seg <= '0;
            o_six_dp        <= '0;
            o_digits        <= '0;
            o_value         <= '0;
            o_frame_valid   <= 1'b0;
            o_err           <= 1'b0;
            o_stale         <= 1'b1;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            seg_buf       <= seg_buf_nx;
            dp_buf        <= dp_buf_nx;
            o_err         <= err_nx;
            o_frame_valid <= complete;
            if (complete || err_nx || tmo_hit) mask <= '0;
            else if (cap)                      mask[slot] <= 1'b1;
            // Counter saturates at the last value and keeps flagging stale
            if (cap)                          tmo_cnt <= '0;
            else if (tmo_cnt == TMO_LAST)     o_stale <= 1'b1;
            else                              tmo_cnt <= tmo_cnt + 32'd1;
            if (complete) begin
                o_six_digit_seg <= seg_buf_nx;
                o_six_dp        <= dp_buf_nx;
                o_digits        <= dig_nx;
                o_value         <= value_nx;
                o_stale         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_rx.sv
// tb/tb_fnd_scan_rx.sv - self-checking bench for fnd_scan_rx against a run-length reference model
module tb_fnd_scan_rx;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;
    localparam logic [6:0] SEG_TBL [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  i_seg = '0;
    logic        i_seg_dp = 1'b0;
    logic [5:0]  i_seg_enb = 6'h3F;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic [23:0] o_digits;
    logic [6:0]  o_value;
    logic        o_frame_valid, o_err, o_stale;

    int tests = 0;
    int fails = 0;
    int n_frames = 0;
    int n_errs = 0;
    bit chk_en = 1'b0;

    fnd_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
        .o_six_digit_seg(o_six_digit_seg), .o_six_dp(o_six_dp), .o_digits(o_digits),
        .o_value(o_value), .o_frame_valid(o_frame_valid), .o_err(o_err), .o_stale(o_stale)
    );

    always #5 clk = ~clk;

    // Reference model: a slot is taken when the synced enable has shown the same
    // single-active value for exactly SETTLE consecutive cycles.
    logic [5:0]  m_s1, m_s2, m_prev, m_mask, m_bdp;
    logic [6:0]  m_g1, m_g2;
    logic        m_p1, m_p2;
    logic [41:0] m_bseg;
    int          m_run, m_since, m_slot, m_n0, m_n1;
    bit          m_legal, m_blank, m_cap, m_full;
    logic [41:0] e_seg;
    logic [5:0]  e_dp;
    logic [23:0] e_dig;
    logic [6:0]  e_val;
    logic        e_fv, e_err, e_stale;

    function automatic logic [3:0] m_decode(input logic [6:0] s);
        logic [3:0] n = 4'hF;
        for (int d = 0; d < 10; d++) if (s == SEG_TBL[d]) n = 4'(d);
        if (s == 7'h00) n = 4'hA;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 6'h3F; m_s2 = 6'h3F; m_prev = 6'h3F;
            m_g1 = '0; m_g2 = '0; m_p1 = 1'b0; m_p2 = 1'b0;
            m_run = 0; m_since = 0; m_mask = '0; m_bseg = '0; m_bdp = '0;
            e_seg = '0; e_dp = '0; e_dig = '0; e_val = '0;
            e_fv = 1'b0; e_err = 1'b0; e_stale = 1'b1;
        end else begin
            m_legal = ($countones(~m_s2) == 1);
            m_blank = (m_s2 == 6'h3F);
            m_run   = (m_s2 == m_prev) ? m_run + 1 : 1;
            m_prev  = m_s2;
            m_cap   = m_legal && (m_run == SETTLE);
            m_full  = (m_mask == 6'h3F);
            m_slot  = 0;
            if (m_cap) begin
                for (int k = 0; k < 6; k++) if (!m_s2[k]) m_slot = k;
                m_bseg[7*m_slot +: 7] = m_g2;
                m_bdp[m_slot] = m_p2;
            end
            e_fv  = m_full;
            e_err = !m_legal && !m_blank;
            if (m_cap) m_since = 0;
            else if (m_since == TMO - 1) begin e_stale = 1'b1; m_mask = '0; end
            else m_since = m_since + 1;
            if (m_full) begin
                e_seg = m_bseg;
                e_dp  = m_bdp;
                for (int k = 0; k < 6; k++) e_dig[4*k +: 4] = m_decode(m_bseg[7*k +: 7]);
                m_n0 = int'(e_dig[3:0]);
                m_n1 = int'(e_dig[7:4]);
                e_val = (m_n0 > 9 || m_n1 > 9) ? 7'h7F : 7'(m_n1 * 10 + m_n0);
                e_stale = 1'b0;
                m_mask = '0;
            end else if (e_err) m_mask = '0;
            else if (m_cap) m_mask[m_slot] = 1'b1;
            m_s2 = m_s1; m_s1 = i_seg_enb;
            m_g2 = m_g1; m_g1 = i_seg;
            m_p2 = m_p1; m_p1 = i_seg_dp;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({o_six_digit_seg, o_six_dp, o_digits, o_value, o_frame_valid, o_err, o_stale} !==
                {e_seg, e_dp, e_dig, e_val, e_fv, e_err, e_stale}) begin
                fails++;
                $display("FAIL model t=%0t: seg %h/%h dp %h/%h dig %h/%h val %0d/%0d fv %b/%b err %b/%b stale %b/%b (got/expected)",
                    $time, o_six_digit_seg, e_seg, o_six_dp, e_dp, o_digits, e_dig, o_value, e_val,
                    o_frame_valid, e_fv, o_err, e_err, o_stale, e_stale);
            end
            if (o_frame_valid) n_frames++;
            if (o_err) n_errs++;
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, actual, required);
        end
    endtask

    task automatic hold(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
        i_seg_enb = enb;
        i_seg = seg;
        i_seg_dp = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_slots(input logic [41:0] segs, input logic [5:0] dps, input int first,
                              input int last, input int dwell);
        logic [5:0] oh;
        for (int k = first; k <= last; k++) begin
            oh = 6'b1 << k;
            hold(~oh, segs[7*k +: 7], dps[k], dwell);
        end
    endtask

    task automatic scan(input logic [41:0] segs, input logic [5:0] dps, input int dwell);
        scan_slots(segs, dps, 0, 5, dwell);
        hold(6'h3F, 7'h00, 1'b0, 10);
    endtask

    logic [41:0] rs;
    logic [5:0]  rd, oh, x6;
    int          f0, e0, r, st;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset_seg", 64'(o_six_digit_seg), 64'h0);
        check("reset_digits", 64'(o_digits), 64'h0);
        check("reset_value", 64'(o_value), 64'h0);
        check("reset_stale", 64'(o_stale), 64'h1);

        // T1: "37"
        scan({28'h0, 7'b1111001, 7'b1110000}, 6'h00, 40);
        check("t1_frames", 64'(n_frames), 64'd1);
        check("t1_digits", 64'(o_digits), 64'hAAAA37);
        check("t1_model_digits", 64'(e_dig), 64'hAAAA37);
        check("t1_value", 64'(o_value), 64'd37);
        check("t1_dp", 64'(o_six_dp), 64'h0);
        check("t1_stale", 64'(o_stale), 64'h0);
        check("t1_seg", 64'(o_six_digit_seg), 64'({28'h0, 7'b1111001, 7'b1110000}));

        // T2: 3-cycle glitch on slot0 never captures it
        hold(6'b111110, 7'b1111110, 1'b0, 3);
        scan_slots({6{7'b0110000}}, 6'h00, 1, 5, 40);
        hold(6'h3F, 7'h00, 1'b0, 10);
        check("t2_no_frame", 64'(n_frames), 64'd1);
        hold(6'b111110, 7'b1111110, 1'b0, 40);
        hold(6'h3F, 7'h00, 1'b0, 10);
        check("t2_frame", 64'(n_frames), 64'd2);
        check("t2_digits", 64'(o_digits), 64'h111110);

        // T3: illegal enable mid-frame
        e0 = n_errs;
        scan_slots({6{7'b1101101}}, 6'h3F, 0, 2, 40);
        hold(6'b111100, 7'b1101101, 1'b0, 1);
        scan_slots({6{7'b1101101}}, 6'h3F, 3, 5, 40);
        hold(6'h3F, 7'h00, 1'b0, 10);
        check("t3_no_frame", 64'(n_frames), 64'd2);
        check("t3_one_err", 64'(n_errs - e0), 64'd1);
        hold(6'b000000, 7'h00, 1'b0, 3);
        hold(6'h3F, 7'h00, 1'b0, 6);
        check("t3_err_each_cycle", 64'(n_errs - e0), 64'd4);
        scan({6{7'b1101101}}, 6'h3F, 40);
        check("t3_frame", 64'(n_frames), 64'd3);
        check("t3_value", 64'(o_value), 64'd22);

        // T4: undecodable pattern in slot2
        scan({7'b1111111, 7'b0110000, 7'b1111110, 7'b1010101, 7'b1110011, 7'b1011011}, 6'b100101, 40);
        check("t4_digits", 64'(o_digits), 64'h810F95);
        check("t4_value", 64'(o_value), 64'd95);
        check("t4_dp", 64'(o_six_dp), 64'b100101);

        // T5: timeout on a partial frame
        f0 = n_frames;
        scan_slots({6{7'b0110011}}, 6'h00, 0, 2, 40);
        hold(6'h3F, 7'h00, 1'b0, 80);
        check("t5_stale", 64'(o_stale), 64'h1);
        check("t5_no_frame", 64'(n_frames - f0), 64'd0);
        check("t5_digits_held", 64'(o_digits), 64'h810F95);

        // T6: reset mid-frame
        scan_slots({6{7'b1011111}}, 6'h00, 0, 3, 40);
        hold(6'h3F, 7'h00, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_digits", 64'(o_digits), 64'h0);
        check("t6_seg", 64'(o_six_digit_seg), 64'h0);
        check("t6_stale", 64'(o_stale), 64'h1);
        f0 = n_frames;
        scan({6{7'b1011111}}, 6'h00, 40);
        check("t6_one_frame", 64'(n_frames - f0), 64'd1);
        check("t6_value", 64'(o_value), 64'd66);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 39);
            if (r == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end else if (r < 20) begin
                for (int k = 0; k < 6; k++) begin
                    rs[7*k +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SEG_TBL[$urandom_range(0, 9)];
                    rd[k] = 1'($urandom);
                end
                st = $urandom_range(0, 5);
                for (int j = 0; j < 6; j++) begin
                    oh = 6'b1 << ((st + j) % 6);
                    hold(~oh, rs[7*((st + j) % 6) +: 7], rd[(st + j) % 6], $urandom_range(4, 45));
                end
                hold(6'h3F, 7'h00, 1'b0, $urandom_range(1, 12));
            end else begin
                for (int j = 0; j < 8; j++) begin
                    r = $urandom_range(0, 29);
                    if (r < 22) begin
                        oh = 6'b1 << $urandom_range(0, 5);
                        x6 = ~oh;
                    end else if (r < 28) x6 = 6'h3F;
                    else begin
                        x6 = 6'($urandom);
                        if ($countones(~x6) <= 1) x6 = 6'b000011;
                    end
                    hold(x6, ($urandom_range(0, 1) == 0) ? SEG_TBL[$urandom_range(0, 9)] : 7'($urandom),
                         1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 70));
                end
            end
        end
        hold(6'h3F, 7'h00, 1'b0, 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
